// File: rtl/paddle_collision_det.sv
// Ball/paddle box overlap detector: 2 register stages feeding a one-shot hit FSM.
// Define COLLISION_HIT_CNT_EN to add the saturating hit_cnt output.
module paddle_collision_det #(
  parameter int BALL_R      = 10,
  parameter int PAD_W       = 20,
  parameter int PAD_H       = 100,
  parameter int L_PAD_X     = 40,
  parameter int R_PAD_X     = 964,
  parameter int HOLD_CYCLES = 800_001
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [11:0] ball_x,
  input  logic [11:0] ball_y,
  input  logic [11:0] lpad_y,
  input  logic [11:0] rpad_y,
  output logic        collision_det,
  output logic        hit_side
`ifdef COLLISION_HIT_CNT_EN
  ,
  output logic [7:0]  hit_cnt
`endif
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [12:0] BALL_R13 = 13'(BALL_R);
  localparam logic [12:0] LX_LO    = 13'(L_PAD_X);
  localparam logic [12:0] LX_HI    = 13'(L_PAD_X + PAD_W + BALL_R);
  localparam logic [12:0] RX_LO    = 13'(R_PAD_X);
  localparam logic [12:0] RX_HI    = 13'(R_PAD_X + PAD_W + BALL_R);
  localparam logic [12:0] Y_SPAN   = 13'(PAD_H + BALL_R);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIT  = 2'd1,
    SEP  = 2'd2
  } state_t;

  logic [11:0] bx_q, by_q, ly_q, ry_q;
  logic        ovl_l_q, ovl_r_q;
  logic [12:0] bx13, by13, ly13, ry13;
  logic        x_l, x_r, y_l, y_r;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_q;
  logic             load_hold;

  always_ff @(posedge pclk) begin
    if (!reset) begin
      bx_q <= '0;
      by_q <= '0;
      ly_q <= '0;
      ry_q <= '0;
    end else begin
      bx_q <= ball_x;
      by_q <= ball_y;
      ly_q <= lpad_y;
      ry_q <= rpad_y;
    end
  end

  // Radius terms sit on the side of the sum so nothing can underflow; touching counts.
  assign bx13 = {1'b0, bx_q};
  assign by13 = {1'b0, by_q};
  assign ly13 = {1'b0, ly_q};
  assign ry13 = {1'b0, ry_q};

  assign x_l = (bx13 + BALL_R13 >= LX_LO) && (bx13 <= LX_HI);
  assign x_r = (bx13 + BALL_R13 >= RX_LO) && (bx13 <= RX_HI);
  assign y_l = (by13 + BALL_R13 >= ly13) && (by13 <= ly13 + Y_SPAN);
  assign y_r = (by13 + BALL_R13 >= ry13) && (by13 <= ry13 + Y_SPAN);

  always_ff @(posedge pclk) begin
    if (!reset) begin
      ovl_l_q <= 1'b0;
      ovl_r_q <= 1'b0;
    end else begin
      ovl_l_q <= x_l & y_l;
      ovl_r_q <= x_r & y_r;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_hold = 1'b0;
    case (state_q)
      IDLE: begin
        if (ovl_l_q | ovl_r_q) begin
          state_d   = HIT;
          load_hold = 1'b1;
        end
      end
      HIT: begin
        if (hold_q == '0) state_d = SEP;
      end
      SEP: begin
        if (!(ovl_l_q | ovl_r_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Left paddle takes priority when both overlap in the same cycle.
  always_ff @(posedge pclk) begin
    if (!reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      hit_side <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_hold) begin
        hold_q   <= HOLD_LOAD;
        hit_side <= ovl_r_q & ~ovl_l_q;
      end else if (state_q == HIT && hold_q != '0) begin
        hold_q <= hold_q - CNT_W'(1);
      end
    end
  end

  assign collision_det = (state_q == HIT);

`ifdef COLLISION_HIT_CNT_EN
  always_ff @(posedge pclk) begin
    if (!reset) begin
      hit_cnt <= 8'd0;
    end else if (load_hold && hit_cnt != 8'hFF) begin
      hit_cnt <= hit_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_paddle_collision_det.sv
// Directed bench for paddle_collision_det with a queue of per-cycle expectations.
// hit_cnt is only checked when COLLISION_HIT_CNT_EN is defined.
module tb_paddle_collision_det;

  typedef struct packed {
    logic        det;
    logic        side;
    logic [7:0]  cnt;
    logic        unit;
    logic [95:0] tag;
  } exp_t;

  logic        pclk;
  logic        reset;
  logic [11:0] bx1, by1, ly1, ry1;
  logic [11:0] bx2, by2, ly2, ry2;
  logic        det1, side1, det2, side2;
`ifdef COLLISION_HIT_CNT_EN
  logic [7:0]  cnt1, cnt2;
`endif

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  paddle_collision_det #(.HOLD_CYCLES(8)) dut (
    .pclk          (pclk),
    .reset         (reset),
    .ball_x        (bx1),
    .ball_y        (by1),
    .lpad_y        (ly1),
    .rpad_y        (ry1),
    .collision_det (det1),
    .hit_side      (side1)
`ifdef COLLISION_HIT_CNT_EN
    ,
    .hit_cnt       (cnt1)
`endif
  );

  // Both paddle boxes coincide so a single ball position overlaps left and right at once.
  paddle_collision_det #(.L_PAD_X(400), .R_PAD_X(400), .HOLD_CYCLES(8)) dut2 (
    .pclk          (pclk),
    .reset         (reset),
    .ball_x        (bx2),
    .ball_y        (by2),
    .lpad_y        (ly2),
    .rpad_y        (ry2),
    .collision_det (det2),
    .hit_side      (side2)
`ifdef COLLISION_HIT_CNT_EN
    ,
    .hit_cnt       (cnt2)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic applyStimulus(input logic unit, input logic rst, input logic [11:0] bx,
                               input logic [11:0] by, input logic [11:0] ly, input logic [11:0] ry);
    reset = rst;
    if (unit) begin
      bx2 = bx; by2 = by; ly2 = ly; ry2 = ry;
    end else begin
      bx1 = bx; by1 = by; ly1 = ly; ry1 = ry;
    end
  endtask

  task automatic pushExp(input int n, input logic det, input logic side, input logic [7:0] cnt,
                         input logic unit, input logic [95:0] tag);
    exp_t e;
    e.det = det; e.side = side; e.cnt = cnt; e.unit = unit; e.tag = tag;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    logic od, os;
    e  = sb.pop_front();
    od = e.unit ? det2 : det1;
    os = e.unit ? side2 : side1;
    compared++;
    assert (od === e.det) else begin
      mismatched++;
      $error("[TB] FAIL %0s collision_det observed=%0b expected=%0b", e.tag, od, e.det);
    end
    compared++;
    assert (os === e.side) else begin
      mismatched++;
      $error("[TB] FAIL %0s hit_side observed=%0b expected=%0b", e.tag, os, e.side);
    end
`ifdef COLLISION_HIT_CNT_EN
    begin
      logic [7:0] oc;
      oc = e.unit ? cnt2 : cnt1;
      compared++;
      assert (oc === e.cnt) else begin
        mismatched++;
        $error("[TB] FAIL %0s hit_cnt observed=%0d expected=%0d", e.tag, oc, e.cnt);
      end
    end
`endif
  endtask

  task automatic drainQueue();
    while (sb.size() != 0) begin
      @(posedge pclk);
      #1;
      checkOutput();
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 12'd2000, 12'd2000, 12'd50, 12'd50);
    applyStimulus(1'b0, 1'b0, 12'd60, 12'd100, 12'd50, 12'd50);
    pushExp(3, 1'b0, 1'b0, 8'd0, 1'b0, "reset");
    drainQueue();

    applyStimulus(1'b0, 1'b1, 12'd60, 12'd100, 12'd50, 12'd50);
    pushExp(2, 1'b0, 1'b0, 8'd0, 1'b0, "left_lat");
    pushExp(8, 1'b1, 1'b0, 8'd1, 1'b0, "left_pulse");
    pushExp(20, 1'b0, 1'b0, 8'd1, 1'b0, "left_sep");
    drainQueue();

    applyStimulus(1'b0, 1'b1, 12'd500, 12'd100, 12'd50, 12'd50);
    pushExp(6, 1'b0, 1'b0, 8'd1, 1'b0, "rearm_away");
    drainQueue();
    applyStimulus(1'b0, 1'b1, 12'd60, 12'd100, 12'd50, 12'd50);
    pushExp(2, 1'b0, 1'b0, 8'd1, 1'b0, "rearm_lat");
    pushExp(8, 1'b1, 1'b0, 8'd2, 1'b0, "rearm_pulse");
    drainQueue();
    applyStimulus(1'b0, 1'b1, 12'd500, 12'd500, 12'd50, 12'd50);
    pushExp(5, 1'b0, 1'b0, 8'd2, 1'b0, "rearm_clr");
    drainQueue();

    applyStimulus(1'b0, 1'b1, 12'd30, 12'd40, 12'd50, 12'd50);
    pushExp(2, 1'b0, 1'b0, 8'd2, 1'b0, "touch_lat");
    pushExp(8, 1'b1, 1'b0, 8'd3, 1'b0, "touch_pulse");
    drainQueue();
    applyStimulus(1'b0, 1'b1, 12'd500, 12'd500, 12'd50, 12'd50);
    pushExp(5, 1'b0, 1'b0, 8'd3, 1'b0, "touch_clr");
    drainQueue();

    applyStimulus(1'b0, 1'b1, 12'd30, 12'd39, 12'd50, 12'd50);
    pushExp(12, 1'b0, 1'b0, 8'd3, 1'b0, "ymiss");
    drainQueue();
    applyStimulus(1'b0, 1'b1, 12'd29, 12'd40, 12'd50, 12'd50);
    pushExp(12, 1'b0, 1'b0, 8'd3, 1'b0, "xmiss");
    drainQueue();

    applyStimulus(1'b0, 1'b1, 12'd954, 12'd0, 12'd50, 12'd0);
    pushExp(2, 1'b0, 1'b0, 8'd3, 1'b0, "right_lat");
    pushExp(8, 1'b1, 1'b1, 8'd4, 1'b0, "right_pulse");
    drainQueue();
    applyStimulus(1'b0, 1'b1, 12'd500, 12'd500, 12'd50, 12'd0);
    pushExp(5, 1'b0, 1'b1, 8'd4, 1'b0, "right_clr");
    drainQueue();

    applyStimulus(1'b0, 1'b1, 12'd60, 12'd100, 12'd50, 12'd50);
    pushExp(2, 1'b0, 1'b1, 8'd4, 1'b0, "midrst_lat");
    pushExp(4, 1'b1, 1'b0, 8'd5, 1'b0, "midrst_hit");
    drainQueue();
    applyStimulus(1'b0, 1'b0, 12'd60, 12'd100, 12'd50, 12'd50);
    pushExp(1, 1'b0, 1'b0, 8'd0, 1'b0, "midrst_abort");
    drainQueue();
    applyStimulus(1'b0, 1'b1, 12'd60, 12'd100, 12'd50, 12'd50);
    pushExp(2, 1'b0, 1'b0, 8'd0, 1'b0, "recover_lat");
    pushExp(8, 1'b1, 1'b0, 8'd1, 1'b0, "recover_hit");
    drainQueue();
    applyStimulus(1'b0, 1'b1, 12'd500, 12'd500, 12'd50, 12'd50);
    pushExp(5, 1'b0, 1'b0, 8'd1, 1'b0, "recover_clr");
    drainQueue();

    applyStimulus(1'b1, 1'b1, 12'd400, 12'd100, 12'd50, 12'd50);
    pushExp(2, 1'b0, 1'b0, 8'd0, 1'b1, "both_lat");
    pushExp(8, 1'b1, 1'b0, 8'd1, 1'b1, "both_pulse");
    pushExp(20, 1'b0, 1'b0, 8'd1, 1'b1, "both_sep");
    drainQueue();

`ifdef COLLISION_HIT_CNT_EN
    for (int h = 0; h < 300; h++) begin
      applyStimulus(1'b0, 1'b1, 12'd60, 12'd100, 12'd50, 12'd50);
      repeat (12) @(posedge pclk);
      #1;
      applyStimulus(1'b0, 1'b1, 12'd500, 12'd500, 12'd50, 12'd50);
      repeat (4) @(posedge pclk);
      #1;
    end
    pushExp(1, 1'b0, 1'b0, 8'd255, 1'b0, "saturate");
    drainQueue();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
